// File: rtl/jitt_gpio_pkg.sv
// Shared constants for the jitter-cleaner GPIO controller: register word offsets,
// the ID value and the pulse engine state encoding.
package jitt_gpio_pkg;

    localparam logic [31:0] JittGpioId = 32'h4A47_0200;

    // Word offsets, i.e. sys_if_addr[7:2]
    localparam logic [5:0] RegId     = 6'h00;
    localparam logic [5:0] RegIn     = 6'h01;
    localparam logic [5:0] RegOut    = 6'h02;
    localparam logic [5:0] RegCfg    = 6'h03;
    localparam logic [5:0] RegDebCnt = 6'h04;
    localparam logic [5:0] RegRiseEn = 6'h05;
    localparam logic [5:0] RegFallEn = 6'h06;
    localparam logic [5:0] RegIrqEn  = 6'h07;
    localparam logic [5:0] RegIrqSts = 6'h08;
    localparam logic [5:0] RegPulse  = 6'h09;

    typedef enum logic {
        PulseIdle,
        PulseActive
    } pulse_state_e;

endpackage

// File: rtl/jitt_gpio_debounce.sv
// One input channel: synchroniser chain, mismatch-count debouncer and edge flags.
module jitt_gpio_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pin_i,
    input  logic [DEB_W-1:0] deb_cnt_i,
    output logic             stable_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DEB_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin_i};
        stable_d = stable_q;
        cnt_d    = '0;
        if (deb_cnt_i == '0) begin
            stable_d = sync;
        end else if (sync != stable_q) begin
            // >= so a threshold lowered mid-count still resolves on the next cycle
            if (cnt_q >= deb_cnt_i - DEB_W'(1)) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_d & ~stable_q;
    assign fall_o   = ~stable_d & stable_q;

endmodule

// File: rtl/jitt_gpio_ctrl.sv
// Register-mapped GPIO controller: register file, edge IRQ and one-shot pulse engine
// on top of per-channel synchronised/debounced inputs.
module jitt_gpio_ctrl
    import jitt_gpio_pkg::*;
#(
    parameter int unsigned          NUM_CH      = 13,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter int unsigned          DEB_W       = 16,
    parameter int unsigned          PULSE_W     = 24,
    parameter logic [NUM_CH-1:0]    OUT_RST     = '0,
    parameter logic [NUM_CH-1:0]    CFG_RST     = '1
) (
    input  logic              sys_if_clk,
    input  logic              sys_if_rstn,
    input  logic              sys_if_wen,
    input  logic [31:0]       sys_if_addr,
    input  logic [31:0]       sys_if_wdata,
    output logic [31:0]       sys_if_rdata,
    input  logic [NUM_CH-1:0] gpio_i,
    output logic [NUM_CH-1:0] gpio_o,
    output logic [NUM_CH-1:0] gpio_t,
    output logic              irq
);

    logic [NUM_CH-1:0]  out_q, out_d, cfg_q, cfg_d;
    logic [NUM_CH-1:0]  rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [NUM_CH-1:0]  irq_en_q, irq_en_d, irq_sts_q, irq_sts_d;
    logic [NUM_CH-1:0]  gpio_o_q, gpio_o_d, pulse_mask, w1c;
    logic [NUM_CH-1:0]  stable, rise, fall;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [PULSE_W-1:0] rem_q, rem_d, pulse_len;
    logic [7:0]         pch_q, pch_d, pulse_ch;
    logic               irq_q, irq_d;
    pulse_state_e       state_q, state_d;
    logic [5:0]         reg_idx;
    logic               unused_bits;

    assign reg_idx     = sys_if_addr[7:2];
    assign pulse_len   = sys_if_wdata[PULSE_W-1:0];
    assign pulse_ch    = sys_if_wdata[31:24];
    assign unused_bits = ^{sys_if_addr[31:8], sys_if_addr[1:0], sys_if_wdata};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        jitt_gpio_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_W      (DEB_W)
        ) u_deb (
            .clk_i    (sys_if_clk),
            .rst_ni   (sys_if_rstn),
            .pin_i    (gpio_i[i]),
            .deb_cnt_i(deb_q),
            .stable_o (stable[i]),
            .rise_o   (rise[i]),
            .fall_o   (fall[i])
        );
    end

    always_comb begin
        out_d     = out_q;
        cfg_d     = cfg_q;
        deb_d     = deb_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        irq_en_d  = irq_en_q;
        w1c       = '0;
        if (sys_if_wen) begin
            case (reg_idx)
                RegOut:    out_d     = sys_if_wdata[NUM_CH-1:0];
                RegCfg:    cfg_d     = sys_if_wdata[NUM_CH-1:0];
                RegDebCnt: deb_d     = sys_if_wdata[DEB_W-1:0];
                RegRiseEn: rise_en_d = sys_if_wdata[NUM_CH-1:0];
                RegFallEn: fall_en_d = sys_if_wdata[NUM_CH-1:0];
                RegIrqEn:  irq_en_d  = sys_if_wdata[NUM_CH-1:0];
                RegIrqSts: w1c       = sys_if_wdata[NUM_CH-1:0];
                default:   ;
            endcase
        end
        // New edges override a simultaneous clear
        irq_sts_d = (irq_sts_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d     = |(irq_sts_q & irq_en_q);
    end

    always_comb begin
        state_d = state_q;
        pch_d   = pch_q;
        rem_d   = rem_q;
        unique case (state_q)
            PulseIdle: begin
                if (sys_if_wen && reg_idx == RegPulse && pulse_ch < 8'(NUM_CH)
                    && pulse_len != '0) begin
                    state_d = PulseActive;
                    pch_d   = pulse_ch;
                    rem_d   = pulse_len;
                end
            end
            PulseActive: begin
                rem_d = rem_q - PULSE_W'(1);
                if (rem_q == PULSE_W'(1)) state_d = PulseIdle;
            end
            default: state_d = PulseIdle;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            pulse_mask[i] = (state_d == PulseActive) && (pch_d == 8'(i));
        end
        gpio_o_d = out_d ^ pulse_mask;
    end

    always_ff @(posedge sys_if_clk or negedge sys_if_rstn) begin
        if (!sys_if_rstn) begin
            out_q     <= OUT_RST;
            cfg_q     <= CFG_RST;
            deb_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            irq_en_q  <= '0;
            irq_sts_q <= '0;
            irq_q     <= 1'b0;
            state_q   <= PulseIdle;
            pch_q     <= '0;
            rem_q     <= '0;
            gpio_o_q  <= OUT_RST;
        end else begin
            out_q     <= out_d;
            cfg_q     <= cfg_d;
            deb_q     <= deb_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            irq_en_q  <= irq_en_d;
            irq_sts_q <= irq_sts_d;
            irq_q     <= irq_d;
            state_q   <= state_d;
            pch_q     <= pch_d;
            rem_q     <= rem_d;
            gpio_o_q  <= gpio_o_d;
        end
    end

    always_comb begin
        sys_if_rdata = '0;
        case (reg_idx)
            RegId:     sys_if_rdata = JittGpioId;
            RegIn:     sys_if_rdata = 32'(stable);
            RegOut:    sys_if_rdata = 32'(out_q);
            RegCfg:    sys_if_rdata = 32'(cfg_q);
            RegDebCnt: sys_if_rdata = 32'(deb_q);
            RegRiseEn: sys_if_rdata = 32'(rise_en_q);
            RegFallEn: sys_if_rdata = 32'(fall_en_q);
            RegIrqEn:  sys_if_rdata = 32'(irq_en_q);
            RegIrqSts: sys_if_rdata = 32'(irq_sts_q);
            RegPulse: begin
                sys_if_rdata[PULSE_W-1:0] = rem_q;
                sys_if_rdata[31]          = (state_q == PulseActive);
            end
            default:   ;
        endcase
    end

    assign gpio_o = gpio_o_q;
    assign gpio_t = cfg_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_jitt_gpio_ctrl.sv
// Directed bench for jitt_gpio_ctrl with default parameters (13 channels, 2 sync stages).
module tb_jitt_gpio_ctrl;

    localparam logic [7:0] AId = 8'h00, AIn = 8'h04, AOut = 8'h08, ACfg = 8'h0C;
    localparam logic [7:0] ADeb = 8'h10, ARise = 8'h14, AIrqEn = 8'h1C;
    localparam logic [7:0] ASts = 8'h20, APulse = 8'h24;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [12:0] gpio_i = '0;
    logic [12:0] gpio_o, gpio_t;
    logic        irq;
    int          n_checks = 0;
    int          n_pass = 0;

    jitt_gpio_ctrl dut (
        .sys_if_clk  (clk),
        .sys_if_rstn (rstn),
        .sys_if_wen  (wen),
        .sys_if_addr (addr),
        .sys_if_wdata(wdata),
        .sys_if_rdata(rdata),
        .gpio_i      (gpio_i),
        .gpio_o      (gpio_o),
        .gpio_t      (gpio_t),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wen = 1'b1; addr = {24'h0, a}; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr = {24'h0, a};
        #1 d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rd(AId, d);
        n_checks++; if (d !== 32'h4A47_0200) $display("FAIL reset_id got %h exp %h", d, 32'h4A47_0200); else n_pass++;
        rd(AOut, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_out got %h exp %h", d, 32'h0); else n_pass++;
        rd(ACfg, d);
        n_checks++; if (d !== 32'h1FFF) $display("FAIL reset_cfg got %h exp %h", d, 32'h1FFF); else n_pass++;
        n_checks++; if (gpio_t !== 13'h1FFF) $display("FAIL reset_gpio_t got %h exp 1fff", gpio_t); else n_pass++;
        n_checks++; if (gpio_o !== 13'h0) $display("FAIL reset_gpio_o got %h exp 0", gpio_o); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_out_cfg();
        logic [31:0] d;
        @(negedge clk);
        wen = 1'b1; addr = {24'h0, AOut}; wdata = 32'h5;
        #1;
        n_checks++; if (gpio_o !== 13'h0) $display("FAIL out_early got %h exp 0", gpio_o); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (gpio_o !== 13'h5) $display("FAIL out_write got %h exp 5", gpio_o); else n_pass++;
        @(negedge clk);
        wen = 1'b0;
        wr(ACfg, 32'h0);
        n_checks++; if (gpio_t !== 13'h0) $display("FAIL cfg_write got %h exp 0", gpio_t); else n_pass++;
        // Bypassed input path: IN follows pin after 3 edges
        gpio_i[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1 rd(AIn, d);
        n_checks++; if (d !== 32'h0) $display("FAIL in_lat2 got %h exp 0", d); else n_pass++;
        @(posedge clk);
        #1 rd(AIn, d);
        n_checks++; if (d !== 32'h8) $display("FAIL in_lat3 got %h exp 8", d); else n_pass++;
        @(negedge clk);
        gpio_i[3] = 1'b0;
        repeat (5) @(negedge clk);
        rd(AIn, d);
        n_checks++; if (d !== 32'h0) $display("FAIL in_back got %h exp 0", d); else n_pass++;
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        wr(ADeb, 32'd10);
        wr(ARise, 32'h1);
        wr(AIrqEn, 32'h1);
        gpio_i[0] = 1'b1;
        repeat (9) @(negedge clk);
        gpio_i[0] = 1'b0;
        repeat (15) @(negedge clk);
        rd(AIn, d);
        n_checks++; if (d !== 32'h0) $display("FAIL glitch_in got %h exp 0", d); else n_pass++;
        rd(ASts, d);
        n_checks++; if (d !== 32'h0) $display("FAIL glitch_sts got %h exp 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL glitch_irq got %b exp 0", irq); else n_pass++;
        gpio_i[0] = 1'b1;
        repeat (11) @(negedge clk);
        rd(AIn, d);
        n_checks++; if (d !== 32'h0) $display("FAIL level_in11 got %h exp 0", d); else n_pass++;
        @(negedge clk);
        rd(AIn, d);
        n_checks++; if (d !== 32'h1) $display("FAIL level_in12 got %h exp 1", d); else n_pass++;
        rd(ASts, d);
        n_checks++; if (d !== 32'h1) $display("FAIL level_sts got %h exp 1", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_early got %b exp 0", irq); else n_pass++;
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_set got %b exp 1", irq); else n_pass++;
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        wr(ADeb, 32'd0);
        gpio_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (2) @(negedge clk);
        // Clear lands on the same edge as the new rise
        wen = 1'b1; addr = {24'h0, ASts}; wdata = 32'h1;
        @(negedge clk);
        wen = 1'b0;
        rd(ASts, d);
        n_checks++; if (d !== 32'h1) $display("FAIL set_wins got %h exp 1", d); else n_pass++;
        wr(ASts, 32'h1);
        rd(ASts, d);
        n_checks++; if (d !== 32'h0) $display("FAIL w1c got %h exp 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b1) $display("FAIL irq_lag got %b exp 1", irq); else n_pass++;
        @(negedge clk);
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_fall got %b exp 0", irq); else n_pass++;
    endtask

    task automatic test_pulse();
        logic [31:0] d;
        int cnt;
        wr(AOut, 32'h1);
        n_checks++; if (gpio_o !== 13'h1) $display("FAIL pulse_pre got %h exp 1", gpio_o); else n_pass++;
        wr(APulse, 32'h0000_0064);
        cnt = 0;
        while (gpio_o[0] === 1'b0 && cnt < 200) begin
            if (cnt == 0) begin
                n_checks++; if (rdata !== 32'h8000_0064) $display("FAIL pulse_start got %h exp 80000064", rdata); else n_pass++;
            end
            if (cnt == 50) begin
                n_checks++; if (rdata !== 32'h8000_0032) $display("FAIL pulse_mid got %h exp 80000032", rdata); else n_pass++;
            end
            if (cnt == 40) begin
                wen = 1'b1; wdata = 32'h0000_0005;
            end else begin
                wen = 1'b0;
            end
            cnt++;
            @(negedge clk);
        end
        wen = 1'b0;
        n_checks++; if (cnt !== 100) $display("FAIL pulse_len got %0d exp 100", cnt); else n_pass++;
        rd(APulse, d);
        n_checks++; if (d !== 32'h0) $display("FAIL pulse_done got %h exp 0", d); else n_pass++;
        wr(APulse, 32'h2800_000A);
        rd(APulse, d);
        n_checks++; if (d !== 32'h0) $display("FAIL pulse_badch got %h exp 0", d); else n_pass++;
        wr(APulse, 32'h0000_0000);
        rd(APulse, d);
        n_checks++; if (d !== 32'h0) $display("FAIL pulse_len0 got %h exp 0", d); else n_pass++;
        n_checks++; if (gpio_o !== 13'h1) $display("FAIL pulse_idle_o got %h exp 1", gpio_o); else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] d;
        wr(APulse, 32'h0200_0064);
        repeat (49) @(negedge clk);
        n_checks++; if (gpio_o !== 13'h5) $display("FAIL mid_pulse_o got %h exp 5", gpio_o); else n_pass++;
        rstn = 1'b0;
        #1;
        n_checks++; if (gpio_o !== 13'h0) $display("FAIL rst_abort_o got %h exp 0", gpio_o); else n_pass++;
        n_checks++; if (gpio_t !== 13'h1FFF) $display("FAIL rst_abort_t got %h exp 1fff", gpio_t); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        rd(APulse, d);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_busy got %h exp 0", d); else n_pass++;
        n_checks++; if (gpio_o !== 13'h0) $display("FAIL rst_after_o got %h exp 0", gpio_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_out_cfg();
        test_debounce();
        test_w1c();
        test_pulse();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
